// File: rtl/bc_arb.sv
// -----------------------------------------------------------------------------
// bc_arb -- arbiter and sequencer for the 16-bit bus-connect datapath.
//
// Four requesters share the bus: dg (DAG), ps (program sequencer), xb
// (crossbar) and dm (data memory). One requester is granted at a time. The
// block also drives the two bus-connect select codes. The dg/ps/xb path has a
// one-cycle register stage, so a DRAIN cycle is inserted whenever dm would
// otherwise take the bus while registered data is still in flight.
//
// Parameters:
//   HOLD_MAX     max consecutive grant cycles for one requester (1..15)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req[3:0]     request vector, [0]=dg [1]=ps [2]=xb [3]=dm, level-held
//   gnt[3:0]     one-hot grant, same bit order (registered)
//   bc_drr_sclt  register-path select: 00 dg, 01 ps, 10 xb, 11 none
//   bc_di_sclt   bus-output select: 00 dm direct, 01 registered path, 11 zero
//   bc_busy      high whenever the arbiter is not IDLE
//
// Configuration:
//   BC_ARB_RR_EN defined   -> round-robin winner selection (dg->ps->xb->dm)
//   BC_ARB_RR_EN undefined -> fixed priority dm > ps > dg > xb
// -----------------------------------------------------------------------------
module bc_arb #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] bc_drr_sclt,
  output logic [1:0] bc_di_sclt,
  output logic       bc_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  localparam logic [1:0] IDX_DG = 2'd0;
  localparam logic [1:0] IDX_PS = 2'd1;
  localparam logic [1:0] IDX_XB = 2'd2;
  localparam logic [1:0] IDX_DM = 2'd3;

  // Last hold count at which the grantee may still keep the bus.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  localparam logic [1:0] DRR_NONE  = 2'b11;
  localparam logic [1:0] DI_DIRECT = 2'b00;
  localparam logic [1:0] DI_REG    = 2'b01;
  localparam logic [1:0] DI_ZERO   = 2'b11;

  state_t     state_r, state_s;
  logic [1:0] g_idx_r, g_idx_s;
  logic [3:0] hold_cnt_r, hold_cnt_s;
  logic [3:0] gnt_r, gnt_s;
  logic [1:0] drr_r, drr_s;
  logic [1:0] di_r, di_s;
  logic       busy_r;
  logic [3:0] cand_s;
  logic       win_vld_s;
  logic [1:0] win_idx_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Register-path select code for a grant vector; dm or no grant -> none.
  function automatic logic [1:0] drr_code(input logic [3:0] g);
    logic [1:0] code;
    case (g)
      4'b0001: code = IDX_DG;
      4'b0010: code = IDX_PS;
      4'b0100: code = IDX_XB;
      default: code = DRR_NONE;
    endcase
    return code;
  endfunction

  // Candidate set: previous grantee excluded when anyone else is waiting.
  always_comb begin
    logic [3:0] excl_v;
    excl_v = req & ~onehot(g_idx_r);
    if (state_r == ST_IDLE) begin
      cand_s = req;
    end else if (excl_v != 4'b0000) begin
      cand_s = excl_v;
    end else begin
      cand_s = req;
    end
  end

`ifdef BC_ARB_RR_EN
  logic [1:0] rr_ptr_r, rr_ptr_s;

  // Round-robin winner: first candidate at or after the search pointer.
  always_comb begin
    logic [1:0] idx_v;
    idx_v     = 2'd0;
    win_vld_s = 1'b0;
    win_idx_s = IDX_DG;
    // Walk from the farthest offset down so the nearest candidate wins.
    for (int i = 3; i >= 0; i--) begin
      idx_v = rr_ptr_r + 2'(i);
      if (cand_s[idx_v]) begin
        win_vld_s = 1'b1;
        win_idx_s = idx_v;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Pointer next value: follows every new grant; DRAIN entry parks it on dm
  // so the drained-for dm request is not overtaken when the DRAIN re-arbitrates.
  always_comb begin
    rr_ptr_s = rr_ptr_r;
    if ((state_r == ST_GRANT) && (state_s == ST_DRAIN)) begin
      rr_ptr_s = IDX_DM;
    end else if ((state_s == ST_GRANT) && (hold_cnt_s == 4'd0)) begin
      rr_ptr_s = win_idx_s + 2'd1;
    end else begin
      rr_ptr_s = rr_ptr_r;
    end
  end

  // Round-robin search pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= 2'd0;
    end else begin
      rr_ptr_r <= rr_ptr_s;
    end
  end
`else
  // Fixed-priority winner: dm > ps > dg > xb.
  always_comb begin
    win_vld_s = |cand_s;
    if (cand_s[IDX_DM]) begin
      win_idx_s = IDX_DM;
    end else if (cand_s[IDX_PS]) begin
      win_idx_s = IDX_PS;
    end else if (cand_s[IDX_DG]) begin
      win_idx_s = IDX_DG;
    end else if (cand_s[IDX_XB]) begin
      win_idx_s = IDX_XB;
    end else begin
      win_idx_s = IDX_DG;
    end
  end
`endif

  // Next-state, next-grant and next-select logic.
  always_comb begin
    state_s    = state_r;
    g_idx_s    = g_idx_r;
    hold_cnt_s = hold_cnt_r;
    gnt_s      = 4'b0000;
    case (state_r)
      ST_IDLE: begin
        hold_cnt_s = 4'd0;
        if (win_vld_s) begin
          state_s = ST_GRANT;
          g_idx_s = win_idx_s;
          gnt_s   = onehot(win_idx_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (req[g_idx_r] && (hold_cnt_r < HOLD_LAST)) begin
          gnt_s      = onehot(g_idx_r);
          hold_cnt_s = hold_cnt_r + 4'd1;
        end else begin
          hold_cnt_s = 4'd0;
          if (!win_vld_s) begin
            state_s = ST_IDLE;
          end else if ((win_idx_s == IDX_DM) && (g_idx_r != IDX_DM)) begin
            // Registered data is still in flight; flush it before dm drives.
            // g_idx_r is kept so DRAIN excludes the same requester.
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_GRANT;
            g_idx_s = win_idx_s;
            gnt_s   = onehot(win_idx_s);
          end
        end
      end
      ST_DRAIN: begin
        hold_cnt_s = 4'd0;
        if (win_vld_s) begin
          state_s = ST_GRANT;
          g_idx_s = win_idx_s;
          gnt_s   = onehot(win_idx_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        hold_cnt_s = 4'd0;
      end
    endcase

    drr_s = drr_code(gnt_s);
    // dm drives the bus in its own grant cycle; registered data lands one
    // cycle after its grant cycle (this also covers the DRAIN cycle).
    if (gnt_s[IDX_DM]) begin
      di_s = DI_DIRECT;
    end else if (|gnt_r[2:0]) begin
      di_s = DI_REG;
    end else begin
      di_s = DI_ZERO;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      g_idx_r    <= IDX_DG;
      hold_cnt_r <= 4'd0;
      gnt_r      <= 4'b0000;
      drr_r      <= DRR_NONE;
      di_r       <= DI_ZERO;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      g_idx_r    <= g_idx_s;
      hold_cnt_r <= hold_cnt_s;
      gnt_r      <= gnt_s;
      drr_r      <= drr_s;
      di_r       <= di_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign gnt         = gnt_r;
  assign bc_drr_sclt = drr_r;
  assign bc_di_sclt  = di_r;
  assign bc_busy     = busy_r;

endmodule

// File: tb/tb_bc_arb.sv
// -----------------------------------------------------------------------------
// tb_bc_arb -- self-checking bench for bc_arb (HOLD_MAX = 4).
// A table of {rst_n, req, expected outputs} records is applied one clock per
// record; outputs are sampled 1 ns after the rising edge. A hand-written
// sequence then times the ps->dm style DRAIN handover with a bounded wait.
// -----------------------------------------------------------------------------
module tb_bc_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] bc_drr_sclt;
  logic [1:0] bc_di_sclt;
  logic       bc_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] drr;
    logic [1:0] di;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  bc_arb #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .bc_drr_sclt(bc_drr_sclt),
    .bc_di_sclt (bc_di_sclt),
    .bc_busy    (bc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                     input logic [1:0] d, input logic [1:0] i, input logic b);
    vec_t v;
    v.rst_n = r; v.req = q; v.gnt = g; v.drr = d; v.di = i; v.busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;
    logic [3:0] mid_gnt;
    logic [1:0] mid_di;
    rst_n = 1'b0;
    req   = 4'b0000;

    // Reset held two cycles with every requester active.
    add(1'b0, 4'b1111, 4'b0000, 2'b11, 2'b11, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 2'b11, 2'b11, 1'b0);
    // Single dg request, then release.
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b11, 1'b1);
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b01, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    // ps granted, then only dm: DRAIN then dm.
    add(1'b1, 4'b0010, 4'b0010, 2'b01, 2'b11, 1'b1);
    add(1'b1, 4'b1000, 4'b0000, 2'b11, 2'b01, 1'b1);
    add(1'b1, 4'b1000, 4'b1000, 2'b11, 2'b00, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    // dm -> dg without DRAIN (di 00 -> 11 -> 01), then dg -> xb pipelined.
    add(1'b1, 4'b1000, 4'b1000, 2'b11, 2'b00, 1'b1);
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b11, 1'b1);
    add(1'b1, 4'b0100, 4'b0100, 2'b10, 2'b01, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b01, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    // Sole requester at hold expiry is re-granted with no gap.
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b11, 1'b1);
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0001, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b01, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    // Reset during DRAIN: no dm grant follows.
    add(1'b1, 4'b0010, 4'b0010, 2'b01, 2'b11, 1'b1);
    add(1'b1, 4'b1000, 4'b0000, 2'b11, 2'b01, 1'b1);
    add(1'b0, 4'b1000, 4'b0000, 2'b11, 2'b11, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);

`ifdef BC_ARB_RR_EN
    // Reset restores pointer 0; req=0011 -> dg x4, ps x4, dg x4.
    add(1'b0, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    add(1'b1, 4'b0011, 4'b0001, 2'b00, 2'b11, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b0011, 4'b0001, 2'b00, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) add(1'b1, 4'b0011, 4'b0010, 2'b01, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) add(1'b1, 4'b0011, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b01, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
`else
    // Fixed priority, req=1111: dm x4, ps x4, DRAIN, dm x4, ps; xb never.
    add(1'b1, 4'b1111, 4'b1000, 2'b11, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 4'b1000, 2'b11, 2'b00, 1'b1);
    add(1'b1, 4'b1111, 4'b0010, 2'b01, 2'b11, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 4'b0010, 2'b01, 2'b01, 1'b1);
    add(1'b1, 4'b1111, 4'b0000, 2'b11, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) add(1'b1, 4'b1111, 4'b1000, 2'b11, 2'b00, 1'b1);
    add(1'b1, 4'b1111, 4'b0010, 2'b01, 2'b11, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b01, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
    // Fixed priority, req=0011: ps x4, dg x4, ps.
    add(1'b1, 4'b0011, 4'b0010, 2'b01, 2'b11, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b0011, 4'b0010, 2'b01, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) add(1'b1, 4'b0011, 4'b0001, 2'b00, 2'b01, 1'b1);
    add(1'b1, 4'b0011, 4'b0010, 2'b01, 2'b01, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b01, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'b11, 2'b11, 1'b0);
`endif

    foreach (vecs[n]) begin
      rst_n = vecs[n].rst_n;
      req   = vecs[n].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d gnt", n), gnt, vecs[n].gnt);
      chk($sformatf("v%0d drr", n), {2'b00, bc_drr_sclt}, {2'b00, vecs[n].drr});
      chk($sformatf("v%0d di", n), {2'b00, bc_di_sclt}, {2'b00, vecs[n].di});
      chk($sformatf("v%0d busy", n), {3'b000, bc_busy}, {3'b000, vecs[n].busy});
    end

    // xb grant, then dm alone: DRAIN must appear exactly once before dm.
    rst_n = 1'b1;
    req   = 4'b0100;
    @(posedge clk);
    #1;
    chk("seq xb gnt", gnt, 4'b0100);
    req     = 4'b1000;
    cyc     = 0;
    mid_gnt = 4'b1111;
    mid_di  = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        mid_gnt = gnt;
        mid_di  = bc_di_sclt;
      end
      if (gnt == 4'b1000) begin
        cyc = c;
        break;
      end
    end
    chk("seq dm latency", 4'(cyc), 4'd2);
    chk("seq drain gnt", mid_gnt, 4'b0000);
    chk("seq drain di", {2'b00, mid_di}, {2'b00, 2'b01});
    chk("seq dm di", {2'b00, bc_di_sclt}, {2'b00, 2'b00});
    req = 4'b0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("seq idle busy", {3'b000, bc_busy}, 4'b0000);
    chk("seq idle di", {2'b00, bc_di_sclt}, {2'b00, 2'b11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bc_arb.md
# bc_arb

Arbiter and sequencer for the 16-bit bus-connect datapath. Four requesters share the bus: DAG (dg), program sequencer (ps), crossbar (xb) and data memory (dm). The block grants one requester at a time and drives the two bus-connect select codes. It also accounts for the one-cycle register stage on the dg/ps/xb path, so a registered transfer never collides with a direct dm transfer.

## Interface
- HOLD_MAX, 4, max consecutive grant cycles for one requester while others wait (1..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req  in  4  request vector: [0]=dg, [1]=ps, [2]=xb, [3]=dm; level-held until served
- gnt  out  4  one-hot grant, same bit order; registered
- bc_drr_sclt  out  2  register-path select: 00 dg, 01 ps, 10 xb, 11 none
- bc_di_sclt  out  2  bus-output select: 00 dm direct, 01 registered path, 11 zero
- bc_busy  out  1  high when state is not IDLE

## Operation
- States:
  - IDLE: no grant. Any req bit goes to GRANT with the arbitration winner.
  - GRANT: grantee g is held.
  - DRAIN: one cycle with no grant, used to flush the register stage.
- Winner selection: fixed priority dm > ps > dg > xb (round-robin under the macro).
- In GRANT with grantee g:
  - req[g] high and hold_cnt < HOLD_MAX-1: keep g, hold_cnt++.
  - req[g] low, or hold_cnt reaches HOLD_MAX-1: re-arbitrate over all req bits, with g excluded if any other bit is set; hold_cnt=0.
  - No requests after re-arbitration: IDLE.
  - Winner is dm and g was dg/ps/xb: go to DRAIN, then grant dm.
- DRAIN: gnt=0, bc_drr_sclt=11, bc_di_sclt=01. Next state is GRANT to the winner re-evaluated in DRAIN, or IDLE.
- Sole requester at hold expiry: re-granted immediately, hold_cnt=0, no gap.
- Select encoding:
  - bc_drr_sclt = code of the current dg/ps/xb grantee, else 11.
  - bc_di_sclt = 00 in any dm-grant cycle.
  - bc_di_sclt = 01 in any cycle following a dg/ps/xb grant cycle (including the DRAIN cycle).
  - bc_di_sclt = 11 otherwise.
- Switches among dg/ps/xb need no DRAIN: the register stage is pipelined, so bc_di_sclt stays 01.
- Switch from dm to dg/ps/xb needs no DRAIN: bc_di_sclt goes 00 → 11 for one cycle, then 01.
- Requester dropping req while waiting: no penalty, no state retained.

## Timing
- All outputs registered.
- req sampled at edge N; gnt valid from edge N+1. Arbitration latency is 1 cycle.
- Registered-path data reaches the bus one cycle after its grant cycle. dm data reaches the bus in its grant cycle.
- Reset (rst_n low at an edge, any state):
  - gnt=0000, bc_drr_sclt=11, bc_di_sclt=11, bc_busy=0.
  - state=IDLE, hold_cnt=0, rr pointer=0.
- Reset mid-transfer abandons the transfer; no DRAIN is issued.
- Simultaneous grant expiry and new request: the new request competes in the same arbitration, with no idle cycle. DRAIN is the only exception.
- Worst-case wait for a requester with req held: 3×HOLD_MAX + 3 cycles (round-robin build).

## Configuration
- BC_ARB_RR_EN defined: round-robin.
  - Search order starts at the bit after the last grantee (dg→ps→xb→dm→dg).
  - Pointer updates on every new grant.
  - HOLD_MAX expiry guarantees fairness.
- Not defined: fixed priority dm > ps > dg > xb.
  - No pointer logic.
  - A lower-priority requester can starve. This is accepted for single-master test builds.

## Test plan
- Reset: rst_n=0 for 2 cycles with req=1111 → gnt=0000, bc_drr_sclt=11, bc_di_sclt=11, bc_busy=0 throughout.
- Single dg request: req=0001 at edge 0 → gnt=0001, bc_drr_sclt=00 at edge 1. bc_di_sclt=01 at edge 2. After req drops: IDLE, bc_di_sclt=11 one cycle after the last grant.
- ps to dm hazard: ps granted, then req=1000 only → one DRAIN cycle (gnt=0000, bc_di_sclt=01), then gnt=1000 with bc_di_sclt=00.
- HOLD_MAX=4, req=0011 held, RR build → grant pattern dg×4, ps×4, dg×4; no idle cycles between grants.
- Fixed priority build, req=1111 held → dm, dm, dm, dm, then ps×4 (dm excluded at expiry), then dm×4. xb is never granted.
- Reset asserted during DRAIN → next edge IDLE, outputs at reset values, no dm grant issued.
